alu_pipe: RTL

- Parametrised successor to the single-cycle execution ALU.
- Registered-output integer ALU with valid/ready handshakes on both sides, tag passthrough for reservation-station/ROB tracking, and a flush input.
- Executes RV32I-style single-cycle ops.
- Adds an iterative multi-cycle multiplier (MUL, low XLEN bits) built as a shift-add state machine.
- Sits between the reservation station (issue side) and the CDB/ROB writeback (result side).

---
 rtl/alu_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered-output integer ALU with valid/ready handshakes on both sides,
// ROB tag passthrough, flush, and an iterative shift-add multiplier.
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete on the fire edge
// MUL   | shift-add multiply in progress, MUL_BITS multiplier bits per rdy cycle
module alu_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_lv,
  input  logic [XLEN-1:0]  in_rv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW   = $clog2(XLEN);
  localparam int ITERS = XLEN / MUL_BITS;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [TAG_W-1:0]  mtag_q, mtag_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   digit_ext;
  logic [XLEN-1:0]   acc_sum;
  logic              in_fire;
  logic              out_fire;
  logic              last_iter;

  assign in_ready   = rdy & ~rst & (state_q == IDLE) & (~out_valid_q | out_ready);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = (state_q == MUL);

  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid_q & out_ready & rdy;
  assign last_iter = (count_q == CW'(ITERS - 1));
  assign shamt     = in_rv[SHW-1:0];

  // Single-cycle result for the op on the issue port; illegal opcodes give 0.
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_lv + in_rv;
      OP_SUB:  alu_res = in_lv - in_rv;
      OP_SLL:  alu_res = in_lv << shamt;
      OP_SRL:  alu_res = in_lv >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(in_lv) >>> shamt);
      OP_AND:  alu_res = in_lv & in_rv;
      OP_OR:   alu_res = in_lv | in_rv;
      OP_XOR:  alu_res = in_lv ^ in_rv;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_lv) < $signed(in_rv))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_lv < in_rv)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: multiplicand times the low MUL_BITS multiplier bits.
  always_comb begin
    digit_ext = '0;
    digit_ext[MUL_BITS-1:0] = mplier_q[MUL_BITS-1:0];
    acc_sum = acc_q + (mcand_q * digit_ext);
  end

  // Next-state, multiplier datapath and output register update.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    mtag_d       = mtag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (in_fire && in_op != OP_MUL) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_res;
            out_tag_d    = in_tag;
          end else begin
            if (out_fire) out_valid_d = 1'b0;
            if (in_fire) begin
              state_d  = MUL;
              mcand_d  = in_lv;
              mplier_d = in_rv;
              mtag_d   = in_tag;
              acc_d    = '0;
              count_d  = '0;
            end
          end
        end
        MUL: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          count_d  = count_q + CW'(1);
          if (last_iter) begin
            state_d      = IDLE;
            count_d      = '0;
            out_valid_d  = 1'b1;
            out_result_d = acc_sum;
            out_tag_d    = mtag_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      mtag_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      mtag_q       <= mtag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule
